// File: rtl/npc_pkg.sv
// npc_pkg: shared constants for the next-PC unit (mode encodings, PC increment).
package npc_pkg;

  localparam int unsigned NPC_SEQ = 0;
  localparam int unsigned NPC_BR  = 1;
  localparam int unsigned NPC_J   = 2;
  localparam int unsigned NPC_JAL = 3;
  localparam int unsigned NPC_JR  = 4;

  localparam int unsigned NPC_INC = 4;

endpackage : npc_pkg

// File: rtl/npc_target_calc.sv
// npc_target_calc: combinational D-stage redirect target and redirect-type decode.
// taken_raw flags a redirect-class mode; the caller qualifies BR with br_cond.
module npc_target_calc
  import npc_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned MODE_W = 3
) (
  input  logic [MODE_W-1:0] npc_mode,
  input  logic [ADDR_W-1:0] pc_d,
  input  logic [ADDR_W-1:0] imm_ext,
  input  logic [25:0]       instr_index,
  input  logic [ADDR_W-1:0] rs_val,
  output logic [ADDR_W-1:0] target,
  output logic              taken_raw
);

  logic [ADDR_W-1:0] pc_plus4;

  // Target select by mode; reserved modes fall back to sequential (not taken).
  always_comb begin
    pc_plus4  = pc_d + ADDR_W'(NPC_INC);
    target    = pc_plus4;
    taken_raw = 1'b0;
    case (npc_mode)
      MODE_W'(NPC_BR): begin
        target    = pc_plus4 + (imm_ext << 2);
        taken_raw = 1'b1;
      end
      MODE_W'(NPC_J), MODE_W'(NPC_JAL): begin
        target    = {pc_plus4[ADDR_W-1:28], instr_index, 2'b00};
        taken_raw = 1'b1;
      end
      MODE_W'(NPC_JR): begin
        target    = rs_val;
        taken_raw = 1'b1;
      end
      default: begin
        target    = pc_plus4;
        taken_raw = 1'b0;
      end
    endcase
  end

endmodule : npc_target_calc

// File: rtl/npc_pipe.sv
// npc_pipe: F-stage PC register with delayed-branch redirects, exception/eret
// redirects and a one-entry pending redirect for imem backpressure.
// Optional macro NPC_RANGE_CHECK_EN: traps unaligned/out-of-range fetch targets
// to EXC_VECTOR and pulses pc_fault.
module npc_pipe
  import npc_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       MODE_W     = 3,
  parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(32'h0000_3000),
  parameter logic [ADDR_W-1:0] EXC_VECTOR = ADDR_W'(32'h0000_4180),
  parameter logic [ADDR_W-1:0] IM_BASE    = ADDR_W'(32'h0000_3000),
  parameter logic [ADDR_W-1:0] IM_SIZE    = ADDR_W'(32'h0000_4000)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              imem_ready,
  input  logic [MODE_W-1:0] npc_mode,
  input  logic              br_cond,
  input  logic [ADDR_W-1:0] pc_d,
  input  logic [ADDR_W-1:0] imm_ext,
  input  logic [25:0]       instr_index,
  input  logic [ADDR_W-1:0] rs_val,
  input  logic              exc_req,
  input  logic              eret_req,
  input  logic [ADDR_W-1:0] epc,
  output logic [ADDR_W-1:0] pc_f,
  output logic              pc_f_valid,
  output logic              redirect_taken,
  output logic              pend_valid,
  output logic              pc_fault
);

`ifdef NPC_RANGE_CHECK_EN
  localparam bit RANGE_CHK = 1'b1;
`else
  localparam bit RANGE_CHK = 1'b0;
`endif

  localparam logic [ADDR_W:0] IM_END = {1'b0, IM_BASE} + {1'b0, IM_SIZE};

  logic [ADDR_W-1:0] target;
  logic              taken_raw;
  logic              is_br;
  logic              advance;
  logic              d_redir;

  logic [ADDR_W-1:0] pend_target;
  logic [ADDR_W-1:0] pc_nxt;
  logic [ADDR_W-1:0] pend_target_nxt;
  logic              pend_valid_nxt;
  logic              fault_nxt;
  logic [ADDR_W-1:0] cand;
  logic              chk;
  logic              illegal;

  npc_target_calc #(
    .ADDR_W (ADDR_W),
    .MODE_W (MODE_W)
  ) u_target_calc (
    .npc_mode    (npc_mode),
    .pc_d        (pc_d),
    .imm_ext     (imm_ext),
    .instr_index (instr_index),
    .rs_val      (rs_val),
    .target      (target),
    .taken_raw   (taken_raw)
  );

  // Redirect qualification: D-stage inputs only count when not stalled.
  always_comb begin
    is_br          = (npc_mode == MODE_W'(NPC_BR));
    advance        = pc_f_valid & imem_ready & ~stall;
    d_redir        = ~stall & pc_f_valid & taken_raw & (~is_br | br_cond);
    redirect_taken = d_redir;
  end

  // Next-state priority; any new fetch address (except exc/eret) goes through cand.
  always_comb begin
    pc_nxt          = pc_f;
    pend_target_nxt = pend_target;
    pend_valid_nxt  = pend_valid;
    fault_nxt       = 1'b0;
    cand            = pc_f;
    chk             = 1'b0;
    illegal         = 1'b0;

    if (exc_req) begin
      pc_nxt         = EXC_VECTOR;
      pend_valid_nxt = 1'b0;
    end else if (eret_req) begin
      pc_nxt         = epc;
      pend_valid_nxt = 1'b0;
    end else if (d_redir && advance) begin
      // The fetch accepted this cycle is the delay slot, so jump straight away.
      cand = target;
      chk  = 1'b1;
    end else if (d_redir) begin
      // Delay slot not yet fetched: park the target until a slot opens.
      pend_target_nxt = target;
      pend_valid_nxt  = 1'b1;
    end else if (pend_valid && advance) begin
      cand           = pend_target;
      pend_valid_nxt = 1'b0;
      chk            = 1'b1;
    end else if (advance) begin
      cand = pc_f + ADDR_W'(NPC_INC);
      chk  = 1'b1;
    end

    if (chk) begin
      illegal = (|cand[1:0]) || (cand < IM_BASE) || ({1'b0, cand} >= IM_END);
      pc_nxt  = cand;
      if (RANGE_CHK && illegal) begin
        pc_nxt         = EXC_VECTOR;
        pend_valid_nxt = 1'b0;
        fault_nxt      = 1'b1;
      end
    end
  end

  // State registers; pc_f_valid sets on the first edge out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_f        <= RESET_PC;
      pc_f_valid  <= 1'b0;
      pend_valid  <= 1'b0;
      pend_target <= '0;
      pc_fault    <= 1'b0;
    end else begin
      pc_f        <= pc_nxt;
      pc_f_valid  <= 1'b1;
      pend_valid  <= pend_valid_nxt;
      pend_target <= pend_target_nxt;
      pc_fault    <= fault_nxt;
    end
  end

endmodule : npc_pipe

// File: doc/npc_pipe.md
Name: npc_pipe

Overview:
Pipelined next-PC unit for the P5 five-stage MIPS core. Holds the F-stage PC register and resolves redirects from the D stage: branch, j, jal and jr with one delay slot. Handles exception and eret redirects and instruction-memory backpressure, latching a redirect that arrives while fetch is blocked. Sits between the hazard unit, the D-stage comparator and instruction memory.

Parameters:
ADDR_W, 32, PC width (>= 32); all PC arithmetic is modulo 2^ADDR_W
MODE_W, 3, width of npc_mode
RESET_PC, 32'h0000_3000, PC after reset
EXC_VECTOR, 32'h0000_4180, exception handler entry
IM_BASE, 32'h0000_3000, lowest legal instruction address (used only with range check)
IM_SIZE, 32'h0000_4000, instruction memory size in bytes (used only with range check)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
stall  in  1  hazard-unit stall of F/D; D-stage redirect inputs are ignored while high
imem_ready  in  1  instruction memory accepts the fetch at pc_f this cycle
npc_mode  in  MODE_W  D-stage control: 0 SEQ, 1 BR, 2 J, 3 JAL, 4 JR, 5-7 reserved (treated as SEQ)
br_cond  in  1  D-stage branch comparison result
pc_d  in  ADDR_W  PC of the D-stage instruction
imm_ext  in  ADDR_W  sign-extended 16-bit immediate
instr_index  in  26  jump index field
rs_val  in  ADDR_W  forwarded GPR[rs] for jr
exc_req  in  1  exception redirect request
eret_req  in  1  eret redirect request
epc  in  ADDR_W  eret target
pc_f  out  ADDR_W  current fetch address
pc_f_valid  out  1  pc_f is a real fetch request
redirect_taken  out  1  combinational; D-stage redirect accepted this cycle
pend_valid  out  1  a redirect is latched and waiting for a fetch slot
pc_fault  out  1  registered one-cycle pulse on an illegal target (range-check build only)

Behaviour:
- Reset values (asynchronous): pc_f=RESET_PC, pc_f_valid=0, pend_valid=0, pend_target=0, pc_fault=0.
- pc_f_valid rises on the first clk edge after reset release and stays high.
- advance = pc_f_valid & imem_ready & ~stall.
- Target computation:
  - BR: pc_d+4+(imm_ext<<2)
  - J/JAL: {(pc_d+4)[ADDR_W-1:28], instr_index, 2'b00}
  - JR: rs_val
- d_redir = ~stall & pc_f_valid & ((mode==BR & br_cond) | mode==J | mode==JAL | mode==JR). redirect_taken = d_redir.
- Next-state priority on each clk edge:
  1. exc_req: pc_f<=EXC_VECTOR, pend_valid<=0. Ignores stall and imem_ready.
  2. eret_req: pc_f<=epc, pend_valid<=0. Ignores stall and imem_ready.
  3. d_redir & advance: pc_f<=target. This is correct because the pc_f fetch accepted this cycle is the delay slot.
  4. d_redir & ~advance: pend_target<=target, pend_valid<=1, pc_f held. The delay slot has not yet been fetched.
  5. pend_valid & advance: pc_f<=pend_target, pend_valid<=0.
  6. advance: pc_f<=pc_f+4.
  7. Otherwise: hold.
- A d_redir while pend_valid=1 overwrites pend_target. Legal code never does this, because a delay slot cannot be a branch.
- Reserved modes, and BR with br_cond=0, behave as SEQ.
- Reset asserted mid-operation discards any pending redirect immediately.

Optional Feature:
NPC_RANGE_CHECK_EN
- Defined: every new pc_f value (redirect, pending, sequential) is checked. If target[1:0]!=0, or target is outside [IM_BASE, IM_BASE+IM_SIZE), then pc_f<=EXC_VECTOR, pend_valid<=0, and pc_fault pulses high for one cycle. exc_req/eret_req targets are exempt from the check.
- Undefined: no check is made, and pc_fault is tied to 0.

Decomposition:
- Package npc_pkg holds:
  - the mode localparams NPC_SEQ=0, NPC_BR=1, NPC_J=2, NPC_JAL=3, NPC_JR=4
  - the PC increment constant 4
- One combinational sub-module, npc_target_calc, takes npc_mode, pc_d, imm_ext, instr_index and rs_val, and produces target and taken_raw.
- npc_pipe keeps the registers, priority logic and range check.

Test Plan:
- Reset, then rst_n released with stall=0 and imem_ready=1: pc_f_valid=0 for 1 cycle, then pc_f = 0x3000, 0x3004, 0x3008.
- pc_d=0x3004, mode=BR, br_cond=1, imm_ext=2, accepted while pc_f=0x3008: next pc_f=0x3010 and redirect_taken=1. Repeat with br_cond=0: next pc_f=0x300C.
- mode=J, pc_d=0x3010, instr_index=0xC10, with imem_ready=0 that cycle: pend_valid=1 and pc_f held. On the cycle imem_ready=1, pc_f advances to 0x3040 and pend_valid=0.
- stall=1 with mode=JR and rs_val=0x3100: pc_f holds and redirect_taken=0. Then stall=0: pc_f=0x3100 next edge.
- exc_req=1 with stall=1 and a pending redirect: pc_f=0x4180 and pend_valid=0. Then eret_req=1 with epc=0x3020: pc_f=0x3020.
- NPC_RANGE_CHECK_EN defined, mode=JR, rs_val=0x3002: pc_f=0x4180 and pc_fault high for exactly 1 cycle. Without the macro: pc_f=0x3002 and pc_fault=0.
